// File: rtl/watch_set_controller.sv
// rtl/watch_set_controller.sv - watch time-setting FSM with field select, auto-repeat, inactivity timeout and field blink
module watch_set_controller #(
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int REPEAT_CYCLES  = 10_000_000,
    parameter int TIMEOUT_CYCLES = 1_000_000_000,
    parameter int BLINK_CYCLES   = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_next,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    output logic       o_run,
    output logic       o_mode,
    output logic       o_hour_tick,
    output logic       o_min_tick,
    output logic       o_sec_tick,
    output logic       o_msec_clear,
    output logic [1:0] o_field,
    output logic       o_blink
);
    localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [RW-1:0] HOLD_LAST    = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REPEAT_LAST  = RW'(REPEAT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    state_t        state;
    logic [2:0]    btn_now;
    logic [2:0]    btn_prev;
    logic [2:0]    btn_armed;
    logic [2:0]    btn_edge;
    logic          next_edge;
    logic          both_high;
    logic          ud_edge;
    logic          in_set;
    logic          rep_held;
    logic          rep_fire;
    logic          fire;
    logic          fire_dir;
    logic          rep_active;
    logic          rep_dir;
    logic          rep_phase;
    logic [RW-1:0] rep_cnt;
    logic [TW-1:0] idle_cnt;
    logic [BW-1:0] blink_cnt;

    // A button only becomes armed once seen low, so a press held across reset never edges.
    assign btn_now   = {i_btn_down, i_btn_up, i_btn_next};
    assign btn_edge  = btn_now & ~btn_prev & btn_armed;
    assign next_edge = btn_edge[0];
    assign both_high = i_btn_up & i_btn_down;
    assign ud_edge   = (btn_edge[1] | btn_edge[2]) & ~both_high;
    assign in_set    = (state != RUN);
    assign rep_held  = rep_dir ? i_btn_down : i_btn_up;
    assign rep_fire  = rep_active & rep_held & ~both_high &
                       (rep_cnt == (rep_phase ? REPEAT_LAST : HOLD_LAST));
    assign fire      = in_set & ~next_edge & (ud_edge | rep_fire);
    assign fire_dir  = ud_edge ? btn_edge[2] : rep_dir;
    assign o_field   = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            o_run        <= 1'b1;
            o_mode       <= 1'b0;
            o_hour_tick  <= 1'b0;
            o_min_tick   <= 1'b0;
            o_sec_tick   <= 1'b0;
            o_msec_clear <= 1'b0;
            o_blink      <= 1'b0;
            btn_prev     <= '0;
            btn_armed    <= '0;
            rep_active   <= 1'b0;
            rep_dir      <= 1'b0;
            rep_phase    <= 1'b0;
            rep_cnt      <= '0;
            idle_cnt     <= '0;
            blink_cnt    <= '0;
        end else begin
            btn_prev     <= btn_now;
            btn_armed    <= btn_armed | ~btn_now;
            o_hour_tick  <= 1'b0;
            o_min_tick   <= 1'b0;
            o_sec_tick   <= 1'b0;
            o_msec_clear <= 1'b0;

            if (!in_set) begin
                o_blink   <= 1'b0;
                blink_cnt <= '0;
            end else if (blink_cnt == BLINK_LAST) begin
                o_blink   <= ~o_blink;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            // rep_phase 0 waits out the initial hold, 1 runs at the repeat period.
            if (fire) begin
                o_hour_tick <= (state == SET_HOUR);
                o_min_tick  <= (state == SET_MIN);
                o_sec_tick  <= (state == SET_SEC);
                o_mode      <= fire_dir;
                o_blink     <= 1'b0;
                blink_cnt   <= '0;
                rep_active  <= 1'b1;
                rep_dir     <= fire_dir;
                rep_phase   <= ~ud_edge;
                rep_cnt     <= '0;
            end else if (!in_set || next_edge || both_high || !rep_held) begin
                rep_active <= 1'b0;
                rep_cnt    <= '0;
            end else if (rep_active) begin
                rep_cnt <= rep_cnt + RW'(1);
            end

            if ((|btn_edge) || fire) begin
                idle_cnt <= '0;
            end else if (in_set) begin
                idle_cnt <= idle_cnt + TW'(1);
            end else begin
                idle_cnt <= '0;
            end

            if (next_edge) begin
                o_blink   <= 1'b0;
                blink_cnt <= '0;
                case (state)
                    RUN:      state <= SET_HOUR;
                    SET_HOUR: state <= SET_MIN;
                    SET_MIN:  state <= SET_SEC;
                    default:  state <= RUN;
                endcase
                o_run        <= (state == SET_SEC);
                o_msec_clear <= (state == SET_SEC);
            end else if (in_set && !fire && !(|btn_edge) && idle_cnt == TIMEOUT_LAST) begin
                state        <= RUN;
                o_run        <= 1'b1;
                o_msec_clear <= 1'b1;
                o_blink      <= 1'b0;
                blink_cnt    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_watch_set_controller.sv
// tb/tb_watch_set_controller.sv - directed and randomized checks of watch_set_controller against a timestamp-based reference model
module tb_watch_set_controller;
    localparam int HOLD = 8;
    localparam int RPT  = 4;
    localparam int TMO  = 50;
    localparam int BLK  = 5;
    localparam logic [8:0] RESET_OUTS = 9'b1_0_0_0_0_0_00_0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       o_run, o_mode, o_hour_tick, o_min_tick, o_sec_tick, o_msec_clear, o_blink;
    logic [1:0] o_field;

    int vectors = 0;
    int miscompares = 0;
    int n_hour, n_min, n_sec, n_clr;

    // Reference model: counters are replaced by timestamps of the last relevant event.
    int       step, m_field, t0, last_act, blink_ref;
    bit       m_mode, m_hour, m_min, m_sec, m_clr, m_blink, rep_on, rep_dir;
    bit [2:0] m_prev, m_armed;

    watch_set_controller #(
        .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(RPT),
        .TIMEOUT_CYCLES(TMO),
        .BLINK_CYCLES(BLK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_btn_next(btn_next),
        .i_btn_up(btn_up),
        .i_btn_down(btn_down),
        .o_run(o_run),
        .o_mode(o_mode),
        .o_hour_tick(o_hour_tick),
        .o_min_tick(o_min_tick),
        .o_sec_tick(o_sec_tick),
        .o_msec_clear(o_msec_clear),
        .o_field(o_field),
        .o_blink(o_blink)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {o_run, o_mode, o_hour_tick, o_min_tick, o_sec_tick, o_msec_clear, o_field, o_blink};
    endfunction

    function automatic logic [8:0] model_outs();
        return {(m_field == 0), m_mode, m_hour, m_min, m_sec, m_clr, 2'(m_field), m_blink};
    endfunction

    function automatic void model_reset();
        step = 0; m_field = 0; t0 = 0; last_act = 0; blink_ref = 0;
        m_mode = 0; m_hour = 0; m_min = 0; m_sec = 0; m_clr = 0; m_blink = 0;
        rep_on = 0; rep_dir = 0; m_prev = 3'b000; m_armed = 3'b000;
    endfunction

    function automatic void model_step(bit n, bit u, bit d);
        bit [2:0] cur, edges;
        bit both, in_set, fire, fdir, held;
        int dt;
        step++;
        cur = {d, u, n};
        edges = cur & ~m_prev & m_armed;
        both = u && d;
        in_set = (m_field != 0);
        m_hour = 0; m_min = 0; m_sec = 0; m_clr = 0;
        fire = 0; fdir = 0;
        if (in_set && !edges[0] && !both) begin
            if (edges[1] || edges[2]) begin
                fire = 1; fdir = edges[2];
                rep_on = 1; rep_dir = edges[2]; t0 = step;
            end else if (rep_on && (rep_dir ? d : u)) begin
                dt = step - t0;
                if (dt == HOLD || (dt > HOLD && (dt - HOLD) % RPT == 0)) begin
                    fire = 1; fdir = rep_dir;
                end
            end
        end
        held = rep_dir ? d : u;
        if (!fire && (!in_set || edges[0] || both || !held)) rep_on = 0;
        if (fire) begin
            case (m_field)
                1: m_hour = 1;
                2: m_min = 1;
                default: m_sec = 1;
            endcase
            m_mode = fdir;
            blink_ref = step;
        end
        if (edges != 3'b000 || fire) last_act = step;
        if (edges[0]) begin
            if (m_field == 3) begin
                m_field = 0; m_clr = 1;
            end else begin
                m_field = m_field + 1; blink_ref = step;
            end
        end else if (in_set && step - last_act == TMO) begin
            m_field = 0; m_clr = 1;
        end
        m_blink = (m_field != 0) ? (((step - blink_ref) / BLK) % 2 == 1) : 1'b0;
        m_prev = cur;
        m_armed = m_armed | ~cur;
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
        model_step(btn_next, btn_up, btn_down);
        n_hour += int'(o_hour_tick);
        n_min  += int'(o_min_tick);
        n_sec  += int'(o_sec_tick);
        n_clr  += int'(o_msec_clear);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step_clk();
    endtask

    task automatic clr_counts();
        n_hour = 0; n_min = 0; n_sec = 0; n_clr = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic press_next();
        btn_next = 1'b1;
        step_clk();
        btn_next = 1'b0;
        step_clk();
    endtask

    task automatic test_reset();
        btn_next = 0; btn_up = 0; btn_down = 0;
        apply_reset();
        vectors++;
        if (outs() !== RESET_OUTS) begin
            miscompares++;
            $display("FAIL reset_state got=%b want=%b", outs(), RESET_OUTS);
        end
    endtask

    task automatic test_field_cycle();
        int want[4] = '{1, 2, 3, 0};
        apply_reset(); idle(2); clr_counts();
        for (int i = 0; i < 4; i++) begin
            btn_next = 1'b1;
            step_clk();
            vectors++;
            if (o_field !== 2'(want[i]) || o_run !== (want[i] == 0)) begin
                miscompares++;
                $display("FAIL field_cycle[%0d] got field=%0d run=%b want field=%0d run=%b",
                         i, o_field, o_run, want[i], (want[i] == 0));
            end
            btn_next = 1'b0;
            idle(2);
        end
        vectors++;
        if (n_clr != 1) begin
            miscompares++;
            $display("FAIL field_cycle_msec_clear got=%0d want=1", n_clr);
        end
    endtask

    task automatic test_single_ticks();
        apply_reset(); idle(2); press_next(); press_next(); clr_counts();
        btn_up = 1'b1;
        step_clk();
        vectors++;
        if (o_min_tick !== 1'b1 || o_mode !== 1'b0 || o_blink !== 1'b0) begin
            miscompares++;
            $display("FAIL up_tick got tick=%b mode=%b blink=%b want 1 0 0", o_min_tick, o_mode, o_blink);
        end
        step_clk(); btn_up = 1'b0; idle(3);
        btn_down = 1'b1;
        step_clk();
        vectors++;
        if (o_min_tick !== 1'b1 || o_mode !== 1'b1) begin
            miscompares++;
            $display("FAIL down_tick got tick=%b mode=%b want 1 1", o_min_tick, o_mode);
        end
        step_clk(); btn_down = 1'b0; idle(3);
        vectors++;
        if (n_min != 2 || n_hour != 0 || n_sec != 0 || o_mode !== 1'b1) begin
            miscompares++;
            $display("FAIL single_tick_totals got min=%0d hour=%0d sec=%0d mode=%b want 2 0 0 1",
                     n_min, n_hour, n_sec, o_mode);
        end
    endtask

    task automatic test_auto_repeat();
        logic [20:0] seen;
        logic [20:0] want;
        want = 21'(1) | (21'(1) << 8) | (21'(1) << 12) | (21'(1) << 16) | (21'(1) << 20);
        seen = '0;
        apply_reset(); idle(2); press_next(); clr_counts();
        btn_up = 1'b1;
        step_clk();
        seen[0] = o_hour_tick;
        for (int k = 1; k <= 20; k++) begin
            step_clk();
            seen[k] = o_hour_tick;
        end
        btn_up = 1'b0;
        idle(12);
        vectors++;
        if (seen !== want) begin
            miscompares++;
            $display("FAIL repeat_offsets got=%b want=%b", seen, want);
        end
        vectors++;
        if (n_hour != 5) begin
            miscompares++;
            $display("FAIL repeat_after_release got=%0d ticks want=5", n_hour);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit done;
        apply_reset(); idle(2); press_next(); press_next();
        btn_next = 1'b1;
        step_clk();
        btn_next = 1'b0;
        n = 0; done = 0;
        while (!done && n < 100) begin
            step_clk();
            n++;
            if (o_field == 2'd0) done = 1;
        end
        vectors++;
        if (n != TMO) begin
            miscompares++;
            $display("FAIL timeout_latency got=%0d cycles want=%0d", n, TMO);
        end
        vectors++;
        if (o_msec_clear !== 1'b1 || o_run !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_outputs got clear=%b run=%b want 1 1", o_msec_clear, o_run);
        end
    endtask

    task automatic test_conflicts();
        apply_reset(); idle(2); press_next(); clr_counts();
        btn_up = 1'b1; btn_down = 1'b1;
        idle(4);
        btn_up = 1'b0; btn_down = 1'b0;
        idle(2);
        vectors++;
        if (n_hour + n_min + n_sec != 0) begin
            miscompares++;
            $display("FAIL both_pressed got=%0d ticks want=0", n_hour + n_min + n_sec);
        end
        btn_next = 1'b1; btn_up = 1'b1;
        step_clk();
        btn_next = 1'b0;
        vectors++;
        if (o_field !== 2'd2 || o_min_tick !== 1'b0 || o_hour_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL next_wins got field=%0d min=%b hour=%b want 2 0 0", o_field, o_min_tick, o_hour_tick);
        end
        idle(12);
        btn_up = 1'b0;
        idle(2);
        vectors++;
        if (n_hour + n_min + n_sec != 0) begin
            miscompares++;
            $display("FAIL next_wins_held got=%0d ticks want=0", n_hour + n_min + n_sec);
        end
        btn_up = 1'b1;
        step_clk();
        btn_up = 1'b0;
        idle(2);
        vectors++;
        if (n_min != 1) begin
            miscompares++;
            $display("FAIL repress_after_release got=%0d ticks want=1", n_min);
        end
    endtask

    task automatic test_reset_mid_repeat();
        apply_reset(); idle(2); press_next(); press_next(); clr_counts();
        btn_up = 1'b1;
        idle(12);
        vectors++;
        if (n_min != 2) begin
            miscompares++;
            $display("FAIL pre_reset_ticks got=%0d want=2", n_min);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (outs() !== RESET_OUTS) begin
            miscompares++;
            $display("FAIL async_reset got=%b want=%b", outs(), RESET_OUTS);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        clr_counts();
        idle(3);
        press_next();
        idle(12);
        vectors++;
        if (o_field !== 2'd1 || n_hour + n_min + n_sec != 0) begin
            miscompares++;
            $display("FAIL held_through_reset got field=%0d ticks=%0d want 1 0", o_field, n_hour + n_min + n_sec);
        end
        btn_up = 1'b0;
        idle(2);
        btn_up = 1'b1;
        step_clk();
        vectors++;
        if (o_hour_tick !== 1'b1) begin
            miscompares++;
            $display("FAIL press_after_reset got=%b want=1", o_hour_tick);
        end
        btn_up = 1'b0;
        idle(2);
    endtask

    task automatic test_random();
        int pn, pu, pd;
        btn_next = 0; btn_up = 0; btn_down = 0;
        apply_reset();
        for (int seg = 0; seg < 8; seg++) begin
            if (seg % 2 == 0) begin
                pn = 40; pu = 100; pd = 60;
            end else begin
                pn = 8; pu = 20; pd = 10;
            end
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 999) < pn) btn_next = ~btn_next;
                if ($urandom_range(0, 999) < pu) btn_up = ~btn_up;
                if ($urandom_range(0, 999) < pd) btn_down = ~btn_down;
                if ($urandom_range(0, 999) == 0) apply_reset();
                step_clk();
                vectors++;
                if (outs() !== model_outs()) begin
                    miscompares++;
                    $display("FAIL random seg%0d step%0d got=%b want=%b", seg, i, outs(), model_outs());
                end
                vectors++;
                if ($countones({o_hour_tick, o_min_tick, o_sec_tick}) > 1) begin
                    miscompares++;
                    $display("FAIL tick_onehot seg%0d step%0d got=%b want at most one",
                             seg, i, {o_hour_tick, o_min_tick, o_sec_tick});
                end
            end
        end
    endtask

    initial begin
        model_reset();
        clr_counts();
        test_reset();
        test_field_cycle();
        test_single_ticks();
        test_auto_repeat();
        test_timeout();
        test_conflicts();
        test_reset_mid_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
